// File: rtl/hash_arb_pkg.sv
// Shared types and constants for the hash-table request arbiter.
package hash_arb_pkg;

  // Command FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Width of the hash-table result word
  localparam int RESULT_W = 64;

  // Status flag positions inside the result word
  localparam int RES_NO_DELETION_TARGET_BIT  = 60;
  localparam int RES_NO_WRITE_SPACE_BIT      = 61;
  localparam int RES_NO_ELEMENT_FOUND_BIT    = 62;
  localparam int RES_KEY_ALREADY_PRESENT_BIT = 63;

  // Command word = 2-bit opcode + data field + key field
  function automatic int cmd_width(input int key_width, input int data_width);
    return 2 + data_width + key_width;
  endfunction

endpackage

// File: rtl/hash_request_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding command.
module tag_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Tag storage; contents are only meaningful while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally; occupancy tracks push/pop with no change on both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/hash_request_arbiter.sv
// Round-robin arbiter sharing one in-order hash-table port among NUM_REQ
// requesters; a tag FIFO steers each returning result back to its issuer.
module hash_request_arbiter
  import hash_arb_pkg::*;
#(
  parameter  int KEY_WIDTH  = 5,
  parameter  int DATA_WIDTH = 25,
  parameter  int NUM_REQ    = 4,
  parameter  int TAG_DEPTH  = 8,
  localparam int CMD_W      = cmd_width(KEY_WIDTH, DATA_WIDTH),
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(TAG_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*CMD_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [RESULT_W-1:0]      rsp_data_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic                     cmd_valid_o,
  output logic [CMD_W-1:0]         cmd_data_o,
  input  logic                     cmd_ready_i,
  input  logic                     tbl_valid_i,
  input  logic [RESULT_W-1:0]      tbl_data_i,
  output logic                     tbl_ready_o,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     proto_err_o
);

  arb_state_e         state_r;
  logic [ID_W-1:0]    grant_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic               cmd_valid_r;
  logic [CMD_W-1:0]   cmd_data_r;
  logic               proto_err_r;

  logic [ID_W-1:0]    pick_s;
  logic [ID_W-1:0]    head_s;
  logic [CNT_W-1:0]   count_s;
  logic               fifo_ne_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] rsp_valid_s;
  logic               tbl_ready_s;

  // One-hot decode of a requester index
  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester at or after ptr, searching upward with wrap
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Round-robin pointer moves just past the requester that was served
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return g + 1'b1;
    end
  endfunction

  assign pick_s    = rr_pick(req_valid_i, rr_ptr_r);
  assign fifo_ne_s = (count_s != '0);
  assign full_s    = (count_s == CNT_W'(TAG_DEPTH));
  assign push_s    = cmd_valid_r & cmd_ready_i;
  assign pop_s     = tbl_valid_i & tbl_ready_s;

  // Command FSM: pick in IDLE, hold grant and command word until accepted in ISSUE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      rr_ptr_r    <= '0;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if ((|req_valid_i) && !full_s) begin
            grant_r     <= pick_s;
            cmd_data_r  <= req_data_i[int'(pick_s)*CMD_W +: CMD_W];
            cmd_valid_r <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            state_r     <= IDLE;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            rr_ptr_r    <= next_ptr(grant_r);
            cmd_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= ISSUE;
          end
        end
        default: begin
          cmd_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Accept strobe to the granted requester and result steering by FIFO head
  always_comb begin
    req_ready_s = '0;
    rsp_valid_s = '0;
    tbl_ready_s = 1'b0;
    if (cmd_valid_r && cmd_ready_i) begin
      req_ready_s = onehot(grant_r);
    end else begin
      req_ready_s = '0;
    end
    if (tbl_valid_i && fifo_ne_s) begin
      rsp_valid_s = onehot(head_s);
    end else begin
      rsp_valid_s = '0;
    end
    if (fifo_ne_s) begin
      tbl_ready_s = rsp_ready_i[head_s];
    end else begin
      tbl_ready_s = 1'b0;
    end
  end

  // Sticky flag for a result that arrives with nothing outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err_r <= 1'b0;
    end else if (tbl_valid_i && !fifo_ne_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_s),
    .push_data (grant_r),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign req_ready_o   = req_ready_s;
  assign rsp_valid_o   = rsp_valid_s;
  assign rsp_data_o    = tbl_data_i;
  assign tbl_ready_o   = tbl_ready_s;
  assign cmd_valid_o   = cmd_valid_r;
  assign cmd_data_o    = cmd_data_r;
  assign outstanding_o = count_s;
  assign proto_err_o   = proto_err_r;

endmodule

// File: doc/hash_request_arbiter.md
Name: hash_request_arbiter

Overview:
- Shares one hash-table command/response port (the 2+DATA_WIDTH+KEY_WIDTH command word in, 64-bit result word out) between NUM_REQ requesters.
- Selects requesters round-robin and forwards one command at a time.
- Records each issued requester index in an in-order tag FIFO and steers every returning result to the requester that issued it.
- Sits between client logic and the hash-table AXI-stream wrapper.

Parameters:
- KEY_WIDTH, 5: key field width of the command word.
- DATA_WIDTH, 25: data field width of the command word.
- NUM_REQ, 4: number of requesters (2..16).
- TAG_DEPTH, 8: maximum outstanding commands, power of two.
- CMD_W, 2+DATA_WIDTH+KEY_WIDTH: command word width (derived, do not override).
- ID_W, clog2(NUM_REQ): requester index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester command valid
- req_data_i  in  NUM_REQ*CMD_W  flattened commands, requester r at [r*CMD_W +: CMD_W]
- req_ready_o  out  NUM_REQ  per-requester command accept
- rsp_valid_o  out  NUM_REQ  per-requester result valid (one-hot or zero)
- rsp_data_o  out  64  result word broadcast to all requesters
- rsp_ready_i  in  NUM_REQ  per-requester result accept
- cmd_valid_o  out  1  command valid to hash table
- cmd_data_o  out  CMD_W  command word to hash table
- cmd_ready_i  in  1  hash table accepts command
- tbl_valid_i  in  1  hash table result valid
- tbl_data_i  in  64  hash table result word
- tbl_ready_o  out  1  result accept to hash table
- outstanding_o  out  clog2(TAG_DEPTH)+1  commands issued but not yet answered
- proto_err_o  out  1  sticky: result arrived with no outstanding tag

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, rr_ptr=0, grant=0;
  - FIFO pointers 0, outstanding_o=0, proto_err_o=0;
  - cmd_valid_o=0, req_ready_o=0, rsp_valid_o=0, tbl_ready_o=0, cmd_data_o=0.
- Reset mid-operation discards all tags. Results returned for pre-reset commands are then untagged and set proto_err_o.
- Command FSM, two states:
  - IDLE, when any req_valid_i is set and outstanding_o < TAG_DEPTH:
    - grant = first valid index at or after rr_ptr, searching cyclically upward with wrap from NUM_REQ-1 to 0;
    - go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - cmd_valid_o=1, cmd_data_o=req_data_i[grant];
    - req_ready_o = one-hot(grant) & cmd_ready_i, all other bits 0;
    - on cmd_ready_i=1: push grant into the tag FIFO, set rr_ptr=(grant+1) mod NUM_REQ, return to IDLE;
    - otherwise hold grant and all outputs unchanged (no re-arbitration while valid is up).
- Latency: a command is presented to the table on the 2nd edge after req_valid_i is seen in IDLE. Throughput is at most one command per 2 cycles.
- Requesters must hold req_valid_i/req_data_i stable until accepted. A requester dropping valid while granted is a protocol violation and is not checked.
- Response path is combinational, with no added latency:
  - head = tag FIFO head, fifo_ne = FIFO not empty;
  - rsp_valid_o = tbl_valid_i & fifo_ne ? one-hot(head) : 0;
  - rsp_data_o = tbl_data_i;
  - tbl_ready_o = fifo_ne & rsp_ready_i[head].
  - On tbl_valid_i & tbl_ready_o, pop the FIFO.
- Untagged result: tbl_valid_i=1 with FIFO empty.
  - tbl_ready_o=0 and proto_err_o sets; it clears only on reset.
  - The result is never delivered.
- outstanding_o: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds TAG_DEPTH; issue is blocked in IDLE at TAG_DEPTH.
- FIFO pointers are clog2(TAG_DEPTH) bits and wrap naturally. Full and empty are derived from outstanding_o.
- Results are assumed returned in command order; the hash table is in-order.

Decomposition:
- Package hash_arb_pkg:
  - state enum {IDLE, ISSUE};
  - function computing CMD_W from KEY_WIDTH/DATA_WIDTH;
  - constant RESULT_W=64;
  - result-word bit positions 60..63 (no_deletion_target, no_write_space, no_element_found, key_already_present).
- One sub-module: tag_fifo, a TAG_DEPTH x ID_W synchronous FIFO with push, pop, head, count, active-low async reset.
- Round-robin selection stays inline as a function.

Test Plan:
- Single requester: requester 2 raises valid with command 0x1_05_0000ABC, table ready=1. Required:
  - cmd_valid_o at edge 2 with that word, req_ready_o=4'b0100 for exactly one cycle;
  - table returns 64'h8000_0000_0000_0ABC; rsp_valid_o=4'b0100 with that data;
  - outstanding_o goes 0→1→0.
- Fairness: all 4 requesters valid continuously, cmd_ready_i=1. Required grant order 0,1,2,3,0,1; no requester is granted twice before all others are granted once.
- Backpressure: cmd_ready_i=0 for 5 cycles while requester 1 is granted. Required:
  - cmd_valid_o and cmd_data_o stay stable;
  - req_valid_i newly raised by requester 0 does not change grant;
  - requester 1 is accepted on the first ready cycle.
- Full: the table never returns results, 9 requests are offered. Required:
  - outstanding_o saturates at 8, cmd_valid_o stays 0;
  - after one result pop, the 9th command issues.
- Routing: commands issued in order 3,0,0,2, then 4 results returned. Required:
  - rsp_valid_o sequence 1000,0001,0001,0100;
  - with rsp_ready_i[0]=0, tbl_ready_o=0 and the FIFO does not pop until requester 0 is ready.
- Error and reset: tbl_valid_i=1 with nothing outstanding sets proto_err_o=1 and tbl_ready_o=0. Asserting reset low with 3 commands outstanding clears everything to 0 immediately, before the next clock edge.
